// File: rtl/qcorr_pkg.sv
// Shared definitions for the quadrature-correlation feature-map path.
// Contents:
//   FEATURE_MAP_RESOLUTION  output element width (input accumulators are twice this)
//   FEATURE_MAP_ADDRWIDE    width of the beat address within one frame
//   st_mqc_beat             one registered output beat {valid, data, addr, marker, last}
//   mqc_state_e             window streamer FSM states
package qcorr_pkg;

   localparam int unsigned FEATURE_MAP_RESOLUTION = 16;
   localparam int unsigned FEATURE_MAP_ADDRWIDE   = 16;

   typedef struct packed {
      logic                                     valid;
      logic signed [FEATURE_MAP_RESOLUTION-1:0] data;
      logic        [FEATURE_MAP_ADDRWIDE-1:0]   addr;
      logic                                     marker;
      logic                                     last;
   } st_mqc_beat;

   // StDrain holds the final beat until it is accepted, then returns to StIdle.
   typedef enum logic [1:0] {StIdle, StStream, StMarker, StDrain} mqc_state_e;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: optional round-half-up, arithmetic right shift, then
// saturation to the signed OUT_W range. All arithmetic is done at IN_W+1 bits so the
// rounding offset can never overflow.
// Ports:
//   wide    in   IN_W signed   accumulator value
//   narrow  out  OUT_W signed  requantized, saturated value
module requant_sat #(
   parameter int unsigned IN_W     = 32,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned SHIFT    = 8,
   parameter int unsigned ROUND_EN = 1
) (
   input  logic signed [IN_W-1:0]  wide,
   output logic signed [OUT_W-1:0] narrow
);

   localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [IN_W:0] RND =
      (ROUND_EN != 0 && SHIFT > 0) ? (IN_W+1)'(1) << RND_POS : (IN_W+1)'(0);
   localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [IN_W:0] sum;
   logic signed [IN_W:0] shifted;

   always_comb begin
      sum     = {wide[IN_W-1], wide} + RND;
      shifted = sum >>> SHIFT;
      if (shifted > MAX_V) begin
         narrow = MAX_V[OUT_W-1:0];
      end else if (shifted < MIN_V) begin
         narrow = MIN_V[OUT_W-1:0];
      end else begin
         narrow = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/mqcr_window_streamer.sv
// Cuts an F_IN_H x F_IN_W window out of an NxN correlation matrix at a runtime position,
// requantizes each element and streams it row-major as valid/ready beats, with an optional
// end-of-row marker beat and a last flag on the final beat. Out-of-matrix positions emit 0.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   acc_data_i              NxN signed matrix, held stable while acc_ready_o is low
//   acc_valid_i/acc_ready_o frame handshake (ready only when idle)
//   start_row_i/start_col_i window origin, sampled at frame accept
//   mqc_valid_o/mqc_ready_i output beat handshake
//   mqc_data_o, mqc_addr_o  requantized element (0 on markers) and beat index in frame
//   mqc_marker_o, mqc_last_o end-of-row marker beat, final beat of frame
module mqcr_window_streamer
   import qcorr_pkg::*;
#(
   parameter int unsigned NUM_CAR_CHANNELS = 35,
   parameter int unsigned F_IN_H           = 13,
   parameter int unsigned F_IN_W           = 29,
   parameter int unsigned IN_W             = 2 * FEATURE_MAP_RESOLUTION,
   parameter int unsigned OUT_W            = FEATURE_MAP_RESOLUTION,
   parameter int unsigned SHIFT            = 8,
   parameter int unsigned ROUND_EN         = 1,
   parameter int unsigned ROW_MARKER_EN    = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_CAR_CHANNELS-1:0][NUM_CAR_CHANNELS-1:0][IN_W-1:0] acc_data_i,
   input  logic                                  acc_valid_i,
   output logic                                  acc_ready_o,
   input  logic [$clog2(NUM_CAR_CHANNELS)-1:0]   start_row_i,
   input  logic [$clog2(NUM_CAR_CHANNELS)-1:0]   start_col_i,
   output logic                                  mqc_valid_o,
   output logic signed [OUT_W-1:0]               mqc_data_o,
   output logic [FEATURE_MAP_ADDRWIDE-1:0]       mqc_addr_o,
   output logic                                  mqc_marker_o,
   output logic                                  mqc_last_o,
   input  logic                                  mqc_ready_i
);

   localparam int unsigned SEL_W  = $clog2(NUM_CAR_CHANNELS);
   localparam int unsigned SPAN   = (F_IN_H > F_IN_W) ? F_IN_H : F_IN_W;
   // Wide enough for origin + offset without wrapping, so padding can be detected.
   localparam int unsigned IDX_W  = $clog2(NUM_CAR_CHANNELS + SPAN);

   mqc_state_e                       state_q, state_d;
   logic [IDX_W-1:0]                 row_q, row_d, col_q, col_d;
   logic [FEATURE_MAP_ADDRWIDE-1:0]  addr_q, addr_d;
   logic [SEL_W-1:0]                 base_row_q, base_row_d, base_col_q, base_col_d;
   st_mqc_beat                       beat_q, beat_d;

   logic                             load, gen_elem, gen_marker, row_last, col_last;
   logic [SEL_W-1:0]                 cur_base_row, cur_base_col;
   logic [IDX_W-1:0]                 win_row, win_col;
   logic signed [IN_W-1:0]           elem_raw;
   logic signed [OUT_W-1:0]          elem;

   assign load     = !beat_q.valid || mqc_ready_i;
   assign row_last = (row_q == IDX_W'(F_IN_H - 1));
   assign col_last = (col_q == IDX_W'(F_IN_W - 1));

   // The first element is produced in the accept cycle, before the origin is registered.
   assign cur_base_row = (state_q == StIdle) ? start_row_i : base_row_q;
   assign cur_base_col = (state_q == StIdle) ? start_col_i : base_col_q;
   assign win_row      = IDX_W'(cur_base_row) + row_q;
   assign win_col      = IDX_W'(cur_base_col) + col_q;

   always_comb begin
      elem_raw = '0;
      if (win_row < IDX_W'(NUM_CAR_CHANNELS) && win_col < IDX_W'(NUM_CAR_CHANNELS)) begin
         elem_raw = acc_data_i[SEL_W'(win_row)][SEL_W'(win_col)];
      end
   end

   requant_sat #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .SHIFT    (SHIFT),
      .ROUND_EN (ROUND_EN)
   ) u_requant (
      .wide   (elem_raw),
      .narrow (elem)
   );

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      addr_d     = addr_q;
      base_row_d = base_row_q;
      base_col_d = base_col_q;
      beat_d     = beat_q;
      gen_elem   = 1'b0;
      gen_marker = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (acc_valid_i) begin
               base_row_d = start_row_i;
               base_col_d = start_col_i;
               gen_elem   = 1'b1;
            end
         end
         StStream: gen_elem   = load;
         StMarker: gen_marker = load;
         StDrain: begin
            if (load) begin
               beat_d  = '0;
               row_d   = '0;
               col_d   = '0;
               addr_d  = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (gen_elem) begin
         beat_d.valid  = 1'b1;
         beat_d.data   = elem;
         beat_d.addr   = addr_q;
         beat_d.marker = 1'b0;
         beat_d.last   = (ROW_MARKER_EN == 0) && row_last && col_last;
         addr_d        = addr_q + FEATURE_MAP_ADDRWIDE'(1);
         if (col_last) begin
            col_d = '0;
            if (ROW_MARKER_EN != 0) begin
               state_d = StMarker;
            end else if (row_last) begin
               state_d = StDrain;
            end else begin
               row_d   = row_q + IDX_W'(1);
               state_d = StStream;
            end
         end else begin
            col_d   = col_q + IDX_W'(1);
            state_d = StStream;
         end
      end

      if (gen_marker) begin
         beat_d.valid  = 1'b1;
         beat_d.data   = '0;
         beat_d.addr   = addr_q;
         beat_d.marker = 1'b1;
         beat_d.last   = row_last;
         addr_d        = addr_q + FEATURE_MAP_ADDRWIDE'(1);
         if (row_last) begin
            state_d = StDrain;
         end else begin
            row_d   = row_q + IDX_W'(1);
            state_d = StStream;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         row_q      <= '0;
         col_q      <= '0;
         addr_q     <= '0;
         base_row_q <= '0;
         base_col_q <= '0;
         beat_q     <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         addr_q     <= addr_d;
         base_row_q <= base_row_d;
         base_col_q <= base_col_d;
         beat_q     <= beat_d;
      end
   end

   assign acc_ready_o  = (state_q == StIdle);
   assign mqc_valid_o  = beat_q.valid;
   assign mqc_data_o   = beat_q.data;
   assign mqc_addr_o   = beat_q.addr;
   assign mqc_marker_o = beat_q.marker;
   assign mqc_last_o   = beat_q.last;

endmodule

// File: tb/tb_mqcr_window_streamer.sv
// Bench for mqcr_window_streamer: requantizer vector table, ramp/padding/backpressure
// frames, mid-frame reset and back-to-back frames without row markers.
module tb_mqcr_window_streamer;
   import qcorr_pkg::*;

   localparam int N = 35;

   typedef struct packed {
      logic        v;
      logic [15:0] d;
      logic [15:0] a;
      logic        m;
      logic        l;
   } obs_t;

   typedef struct {
      logic [31:0] x;
      logic [15:0] trunc;
      logic [15:0] rnd;
   } rq_vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0][N-1:0][31:0] acc_data;

   logic        acc_valid0 = 1'b0, acc_ready0, mqc_valid0, mqc_marker0, mqc_last0;
   logic        mqc_ready0 = 1'b1;
   logic [5:0]  start_row0 = '0, start_col0 = '0;
   logic [15:0] mqc_data0, mqc_addr0;

   logic        acc_valid1 = 1'b0, acc_ready1, mqc_valid1, mqc_marker1, mqc_last1;
   logic        mqc_ready1 = 1'b1;
   logic [5:0]  start_row1 = '0, start_col1 = '0;
   logic [15:0] mqc_data1, mqc_addr1;

   logic [31:0] rq_in = '0;
   logic [15:0] rq_t, rq_r;

   obs_t obs0, obs1;
   assign obs0 = {mqc_valid0, mqc_data0, mqc_addr0, mqc_marker0, mqc_last0};
   assign obs1 = {mqc_valid1, mqc_data1, mqc_addr1, mqc_marker1, mqc_last1};

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mqcr_window_streamer #(.ROUND_EN(0), .ROW_MARKER_EN(1)) dut0 (
      .clk_i(clk), .rst_i(rst), .acc_data_i(acc_data), .acc_valid_i(acc_valid0),
      .acc_ready_o(acc_ready0), .start_row_i(start_row0), .start_col_i(start_col0),
      .mqc_valid_o(mqc_valid0), .mqc_data_o(mqc_data0), .mqc_addr_o(mqc_addr0),
      .mqc_marker_o(mqc_marker0), .mqc_last_o(mqc_last0), .mqc_ready_i(mqc_ready0)
   );

   mqcr_window_streamer #(.ROUND_EN(1), .ROW_MARKER_EN(0)) dut1 (
      .clk_i(clk), .rst_i(rst), .acc_data_i(acc_data), .acc_valid_i(acc_valid1),
      .acc_ready_o(acc_ready1), .start_row_i(start_row1), .start_col_i(start_col1),
      .mqc_valid_o(mqc_valid1), .mqc_data_o(mqc_data1), .mqc_addr_o(mqc_addr1),
      .mqc_marker_o(mqc_marker1), .mqc_last_o(mqc_last1), .mqc_ready_i(mqc_ready1)
   );

   requant_sat #(.IN_W(32), .OUT_W(16), .SHIFT(8), .ROUND_EN(0)) u_rq_t (
      .wide(rq_in), .narrow(rq_t)
   );
   requant_sat #(.IN_W(32), .OUT_W(16), .SHIFT(8), .ROUND_EN(1)) u_rq_r (
      .wide(rq_in), .narrow(rq_r)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Ramp matrix holds (i*N+j)<<8, so with SHIFT=8 every in-range element is i*N+j exactly.
   function automatic int exp_elem(input int i, input int j);
      return (i < N && j < N) ? i * N + j : 0;
   endfunction

   function automatic obs_t exp0(input int sr, input int sc, input int k);
      obs_t e;
      int r, p;
      r = k / 30;
      p = k % 30;
      e.v = 1'b1;
      e.a = 16'(k);
      e.l = (k == 389);
      if (p == 29) begin
         e.m = 1'b1;
         e.d = '0;
      end else begin
         e.m = 1'b0;
         e.d = 16'(exp_elem(sr + r, sc + p));
      end
      return e;
   endfunction

   function automatic obs_t exp1(input int k);
      obs_t e;
      e.v = 1'b1;
      e.a = 16'(k);
      e.m = 1'b0;
      e.l = (k == 376);
      e.d = 16'(exp_elem(6 + k / 29, k % 29));
      return e;
   endfunction

   // Entered and left at a negedge. Compares accepted beats 0..stop-1 against the model;
   // ready is low with probability pct percent.
   task automatic run_frame(input int sr, input int sc, input int pct, input int stop);
      int   k;
      int   cyc;
      logic held;
      obs_t prev;
      k = 0;
      cyc = 0;
      held = 1'b0;
      prev = '0;
      start_row0 = 6'(sr);
      start_col0 = 6'(sc);
      acc_valid0 = 1'b1;
      @(posedge clk);
      #1;
      acc_valid0 = 1'b0;
      start_row0 = 6'd1;  // must be ignored while busy
      start_col0 = 6'd2;
      while (k < stop && cyc < 20000) begin
         mqc_ready0 = ($urandom_range(0, 99) >= pct);
         @(negedge clk);
         if (held) chk("hold_stable", obs0, prev);
         held = mqc_valid0 && !mqc_ready0;
         prev = obs0;
         if (mqc_valid0 && mqc_ready0) begin
            chk("beat", obs0, exp0(sr, sc, k));
            k++;
         end
         if (k < stop) begin
            @(posedge clk);
            #1;
         end
         cyc++;
      end
      chk("beat_count", 64'(k), 64'(stop));
      mqc_ready0 = 1'b1;
      if (stop == 390) begin
         @(negedge clk);
         chk("frame_end_idle", {acc_ready0, mqc_valid0}, 2'b10);
      end
   endtask

   rq_vec_t rq_tab[13];
   int gap, rdy;

   initial begin
      rq_tab[0]  = '{32'h7FFF_FF00, 16'd32767, 16'd32767};
      rq_tab[1]  = '{32'h8000_0000, 16'h8000, 16'h8000};
      rq_tab[2]  = '{32'h0000_0180, 16'd1, 16'd2};
      rq_tab[3]  = '{32'hFFFF_FE80, 16'hFFFE, 16'hFFFF};
      rq_tab[4]  = '{32'h0000_0000, 16'd0, 16'd0};
      rq_tab[5]  = '{32'h0000_007F, 16'd0, 16'd0};
      rq_tab[6]  = '{32'h0000_0080, 16'd0, 16'd1};
      rq_tab[7]  = '{32'hFFFF_FF80, 16'hFFFF, 16'd0};
      rq_tab[8]  = '{32'h007F_FF00, 16'd32767, 16'd32767};
      rq_tab[9]  = '{32'h0080_0000, 16'd32767, 16'd32767};
      rq_tab[10] = '{32'hFF80_0000, 16'h8000, 16'h8000};
      rq_tab[11] = '{32'hFF7F_FF00, 16'h8000, 16'h8000};
      rq_tab[12] = '{32'h7FFF_FFFF, 16'd32767, 16'd32767};

      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            acc_data[i][j] = 32'((i * N + j) << 8);

      @(negedge clk);
      chk("reset_out0", obs0, '0);
      chk("reset_out1", obs1, '0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready0", {acc_ready0, mqc_valid0}, 2'b10);
      chk("idle_ready1", {acc_ready1, mqc_valid1}, 2'b10);

      for (int i = 0; i < 13; i++) begin
         rq_in = rq_tab[i].x;
         #1;
         chk("rq_trunc", rq_t, rq_tab[i].trunc);
         chk("rq_round", rq_r, rq_tab[i].rnd);
      end
      @(negedge clk);

      run_frame(6, 0, 0, 390);    // ramp
      run_frame(30, 20, 0, 390);  // zero padding
      run_frame(6, 0, 30, 390);   // backpressure

      // Reset while beat 100 is being presented.
      run_frame(6, 0, 0, 100);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out", obs0, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_idle", {acc_ready0, mqc_valid0}, 2'b10);
      run_frame(6, 0, 0, 390);    // restarts from addr 0

      // Continuous acc_valid, no markers: 377-beat frames with one idle cycle between.
      start_row1 = 6'd6;
      start_col1 = 6'd0;
      acc_valid1 = 1'b1;
      for (int f = 0; f < 3; f++) begin
         gap = 0;
         rdy = 0;
         while (!mqc_valid1 && gap < 20) begin
            if (acc_ready1) rdy++;
            gap++;
            @(negedge clk);
         end
         chk("b2b_gap", 64'(gap), 64'd1);
         chk("b2b_ready_pulse", 64'(rdy), 64'd1);
         for (int k = 0; k < 377; k++) begin
            chk("b2b_beat", obs1, exp1(k));
            if (acc_ready1) chk("b2b_busy_ready", acc_ready1, 1'b0);
            if (f == 2 && k == 376) acc_valid1 = 1'b0;
            @(negedge clk);
         end
      end
      chk("b2b_end_idle", {acc_ready1, mqc_valid1}, 2'b10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
